bcd_tens_comp_serial: RTL and testbench
=======================================

BCD_TENS_COMP_SERIAL -- requirements
Module: bcd_tens_comp_serial

Interface
REQ-001 SHALL have parameter NDIG, default 8, meaning the maximum number of digits per word (legal range 2..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: in_digit and in_last are valid this cycle.
REQ-005 SHALL have port in_digit, input, 4 bits: BCD digit; words arrive least-significant digit first.
REQ-006 SHALL have port in_last, input, 1 bit: marks the most-significant (final) digit of a word.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an input digit this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: the out_* fields hold a result digit.
REQ-009 SHALL have port out_digit, output, 4 bits: ten's-complement BCD digit.
REQ-010 SHALL have port out_last, output, 1 bit: final digit of the output word.
REQ-011 SHALL have port out_err, output, 1 bit: digit is invalid or belongs to an invalid word.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the output digit.

Function
REQ-013 SHALL transfer an input digit only when in_valid && in_ready, and an output digit only when out_valid && out_ready.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (single output register, combinational ready, no bubble).
REQ-015 SHALL produce the output registered exactly 1 cycle after input acceptance (latency 1, throughput 1 digit/cycle).
REQ-016 SHALL hold all out_* fields stable while out_valid && !out_ready.
REQ-017 SHALL clear out_valid after a transfer when no new input digit is accepted in the same cycle.
REQ-018 SHALL use FSM states FIRST (next digit starts a word; carry = 1) and MID (inside a word; carry = the registered value).
REQ-019 SHALL compute per digit: s = (9 - in_digit) + carry; if s == 10 then out_digit = 0 and next carry = 1, else out_digit = s and next carry = 0.
REQ-020 SHALL transition FIRST->MID on an accepted digit with in_last = 0, and MID->FIRST on an accepted digit with in_last = 1.
REQ-021 SHALL also transition FIRST->FIRST on an accepted digit with in_last = 1 (single-digit word).
REQ-022 SHALL discard the carry out of the final digit of a word.
REQ-023 SHALL treat in_digit > 9 as invalid: out_digit = 0, out_err = 1, carry cleared to 0.
REQ-024 SHALL keep out_err = 1 on every later digit of a word once the word contains an invalid digit.
REQ-025 SHALL keep a digit counter (4 bits); at the NDIG-th digit of a word without in_last, it SHALL force out_last = 1 and out_err = 1 and return to FIRST.
REQ-026 SHALL pass out_last equal to in_last, except in the forced case of REQ-025.
REQ-027 SHALL ignore in_digit and in_last whenever no input transfer occurs.

Reset
REQ-028 SHALL, while rst_n = 0 at a clock edge, set out_valid = 0, out_digit = 0, out_last = 0, out_err = 0, state = FIRST, carry = 1, digit count = 0 and the sticky error = 0.
REQ-029 SHALL discard any partially accepted word on a mid-word reset; the next accepted digit starts a new word.
REQ-030 SHALL drive in_ready = 1 during and immediately after reset (out_valid = 0).

Structure
REQ-031 SHALL take the state enum (FIRST, MID) and the constant BCD_NINE = 4'd9 from the shared package bcd_pkg.
REQ-032 SHALL use one combinational sub-module, bcd_nines_comp (4-bit digit in, 4-bit 9's complement out, invalid flag out).
REQ-033 SHALL use no latches, no multiple clocks and no asynchronous logic.

Verification
REQ-034 Single digit 0, last -> out 0, out_last 1, out_err 0.
REQ-035 Word 25 (digits 5, 2 last) -> output 5, 7 (75), out_last on 7; word 100 (0, 0, 1 last) -> 0, 0, 9.
REQ-036 Digits 4, C, 3 last -> outputs 6, 0, 6 with out_err = 0, 1, 1; the next word 7 last -> 3, out_err 0.
REQ-037 out_ready held 0 for 3 cycles on word 25 -> out_digit stays 5 and in_ready = 0; no digit is lost or duplicated after release.
REQ-038 NDIG = 8 and 8 digits of 0 with no last -> eighth output forced out_last = 1, out_err = 1; the following digit restarts with carry 1.
REQ-039 rst_n = 0 after digit 5 of word 25 -> out_valid = 0; after reset, digits 2, last -> output 8 (a new word).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD ten's-complement datapath.
package bcd_pkg;

    localparam logic [3:0] BCD_NINE = 4'd9;

    typedef enum logic {
        FIRST = 1'b0,
        MID   = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_nines_comp.sv
// Combinational nine's complement of one BCD digit; codes above nine are
// flagged invalid and complement to zero.
module bcd_nines_comp
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_comp,
    output logic       o_invalid
);

    logic w_invalid;

    assign w_invalid = (i_digit > BCD_NINE);
    assign o_invalid = w_invalid;
    assign o_comp    = w_invalid ? 4'd0 : (BCD_NINE - i_digit);

endmodule

// File: rtl/bcd_tens_comp_serial.sv
// Serial ten's complement of BCD words streamed LSD first, one digit per
// cycle through a single skid-free output register.
module bcd_tens_comp_serial
    import bcd_pkg::*;
#(
    parameter int NDIG = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_last,
    output logic       out_err,
    input  logic       out_ready
);

    localparam logic [3:0] NDIG_L = 4'(NDIG);

    state_t     r_state;
    logic       r_carry;
    logic [3:0] r_cnt;
    logic       r_sticky;
    logic       r_out_valid;
    logic [3:0] r_out_digit;
    logic       r_out_last;
    logic       r_out_err;

    logic       w_accept;
    logic [3:0] w_comp;
    logic       w_invalid;
    logic       w_carry_in;
    logic       w_sticky_in;
    logic [3:0] w_sum;
    logic       w_wrap;
    logic [3:0] w_cnt;
    logic       w_forced;
    logic       w_end;
    logic       w_word_err;

    bcd_nines_comp u_nines (
        .i_digit   (in_digit),
        .o_comp    (w_comp),
        .o_invalid (w_invalid)
    );

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // A new word always starts with carry 1 and a clean error history,
    // regardless of what the previous word left in the registers.
    assign w_carry_in  = (r_state == FIRST) ? 1'b1 : r_carry;
    assign w_sticky_in = (r_state == FIRST) ? 1'b0 : r_sticky;
    assign w_sum       = w_comp + {3'd0, w_carry_in};
    assign w_wrap      = (w_sum == 4'd10);

    assign w_cnt      = ((r_state == FIRST) ? 4'd0 : r_cnt) + 4'd1;
    assign w_forced   = !in_last && (w_cnt == NDIG_L);
    assign w_end      = in_last || w_forced;
    assign w_word_err = w_invalid || w_sticky_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FIRST;
            r_carry     <= 1'b1;
            r_cnt       <= 4'd0;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_digit <= 4'd0;
            r_out_last  <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_digit <= (w_invalid || w_wrap) ? 4'd0 : w_sum;
            r_out_last  <= w_end;
            r_out_err   <= w_word_err || w_forced;
            r_carry     <= !w_invalid && w_wrap;
            r_state     <= w_end ? FIRST : MID;
            r_cnt       <= w_end ? 4'd0 : w_cnt;
            r_sticky    <= w_end ? 1'b0 : w_word_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_digit = r_out_digit;
    assign out_last  = r_out_last;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_bcd_tens_comp_serial.sv
// Directed bench: word-level arithmetic model plus literal expectations.
module tb_bcd_tens_comp_serial;

    localparam int NDIG = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_digit;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_last;
    logic       out_err;
    logic       out_ready;

    int n_chk  = 0;
    int n_pass = 0;

    logic [5:0] exp_q[$];   // {digit, last, err} predicted by the model
    logic [5:0] act_q[$];   // {digit, last, err} actually transferred
    int         wbuf[$];    // digits of the word currently being received

    bcd_tens_comp_serial #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_digit (out_digit),
        .out_last  (out_last),
        .out_err   (out_err),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: low digits of a ten's complement depend only on the low digits of
    // the operand, so each output digit is taken from (10^k - prefix) mod 10^k.
    // Digits from the first invalid one onward are flagged; after it the carry
    // chain is broken, leaving plain 9-d.
    function automatic logic [5:0] model_digit(input int d, input bit last);
        longint pv, pw, comp;
        int     idx, bad, od;
        bit     forced, err;
        wbuf.push_back(d);
        idx = wbuf.size() - 1;
        bad = -1;
        for (int i = 0; i <= idx; i++) if (bad < 0 && wbuf[i] > 9) bad = i;
        if (bad < 0) begin
            pv = 0; pw = 1;
            for (int i = 0; i <= idx; i++) begin
                pv += longint'(wbuf[i]) * pw;
                pw *= 10;
            end
            comp = (pw - pv) % pw;
            od   = int'((comp / (pw / 10)) % 10);
        end else if (bad == idx) od = 0;
        else od = 9 - d;
        forced = !last && (idx + 1 == NDIG);
        err    = (bad >= 0) || forced;
        if (last || forced) wbuf.delete();
        return {od[3:0], last || forced, err};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            wbuf.delete();
        end else begin
            chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_out", 1, 0);
                else chk("out_fields", int'({out_digit, out_last, out_err}), int'(exp_q.pop_front()));
                act_q.push_back({out_digit, out_last, out_err});
            end
            if (in_valid && in_ready) exp_q.push_back(model_digit(int'(in_digit), in_last));
        end
    end

    task automatic send(input logic [3:0] d, input logic last);
        bit ok = 0;
        in_valid = 1'b1; in_digit = d; in_last = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_digit = 4'hF; in_last = 1'b1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int d, input bit l, input bit e);
        if (act_q.size() == 0) chk({name, "_missing"}, 0, 1);
        else chk(name, int'(act_q.pop_front()), int'({d[3:0], l, e}));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_digit = 4'd0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_fields", int'({out_digit, out_last, out_err}), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;

        send(4'd0, 1'b1);
        drain();
        expect_out("single_zero", 0, 1, 0);

        send(4'd5, 1'b0); send(4'd2, 1'b1);
        send(4'd0, 1'b0); send(4'd0, 1'b0); send(4'd1, 1'b1);
        drain();
        expect_out("w25_d0", 5, 0, 0);
        expect_out("w25_d1", 7, 1, 0);
        expect_out("w100_d0", 0, 0, 0);
        expect_out("w100_d1", 0, 0, 0);
        expect_out("w100_d2", 9, 1, 0);

        send(4'd4, 1'b0); send(4'hC, 1'b0); send(4'd3, 1'b1);
        send(4'd7, 1'b1);
        drain();
        expect_out("bad_d0", 6, 0, 0);
        expect_out("bad_d1", 0, 0, 1);
        expect_out("bad_d2", 6, 1, 1);
        expect_out("after_bad", 3, 1, 0);

        // Backpressure: hold the first result of word 25 for three cycles.
        out_ready = 1'b0;
        send(4'd5, 1'b0);
        fork
            send(4'd2, 1'b1);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_digit", int'(out_digit), 5);
                    chk("stall_in_ready", int'(in_ready), 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        expect_out("stall_d0", 5, 0, 0);
        expect_out("stall_d1", 7, 1, 0);
        chk("stall_no_dup", act_q.size(), 0);

        for (int i = 0; i < NDIG; i++) send(4'd0, 1'b0);
        send(4'd3, 1'b1);
        drain();
        for (int i = 0; i < NDIG - 1; i++) expect_out("long_zero", 0, 0, 0);
        expect_out("long_forced", 0, 1, 1);
        expect_out("long_restart", 7, 1, 0);

        send(4'd5, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        send(4'd2, 1'b1);
        drain();
        expect_out("post_rst", 8, 1, 0);

        // Longer mixed stream checked by the model only.
        send(4'd9, 1'b0); send(4'd9, 1'b0); send(4'd0, 1'b0); send(4'd3, 1'b1);
        send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'hA, 1'b0); send(4'd8, 1'b0); send(4'd0, 1'b1);
        drain();
        chk("model_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
